fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Next-PC generator for the dual-issue fetch front end. Sits directly upstream of the branch target buffer and the IF stage.
- Holds the architectural fetch PC and presents a 2-instruction, 8-byte-aligned fetch bundle (instr0_pc, instr1_pc) to the BTB and IF.
- Uses the same-cycle BTB hit/target results plus EXE redirects and IF back-pressure to choose the next bundle address.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- XLEN_WIDTH, 32, PC width; equals the Falco_pkg value.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- if_ready  in  1  IF stage accepts the current bundle this cycle
- redirect_valid  in  1  EXE mispredict/exception redirect
- redirect_target  in  XLEN_WIDTH  redirect PC
- halt_req  in  1  stop fetching (WFI/ebreak) until next redirect
- instr0_btb_hit  in  1  BTB hit for instr0_pc (combinational from BTB)
- instr0_btb_target_addr  in  XLEN_WIDTH  BTB target for instr0
- instr1_btb_hit  in  1  BTB hit for instr1_pc
- instr1_btb_target_addr  in  XLEN_WIDTH  BTB target for instr1
- instr0_pc  out  XLEN_WIDTH  bundle slot-0 PC (to BTB and IF)
- instr1_pc  out  XLEN_WIDTH  instr0_pc+4
- fetch_valid  out  1  bundle valid
- instr1_valid  out  1  slot 1 belongs to the predicted path
- pred_taken  out  1  bundle ends in a BTB-predicted-taken branch
- perf_redirect_cnt  out  32  redirect count (see Optional Feature)
- perf_pred_taken_cnt  out  32  accepted predicted-taken bundles count

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- State register pc_q, plus FSM states S_BOOT, S_RUN, S_HALT.
- Reset (async, rst=1):
  - pc_q=BOOT_ADDR, state=S_BOOT.
  - fetch_valid=0, instr1_valid=0, pred_taken=0, counters=0.
  - A reset asserted mid-operation discards everything, including any pending redirect.
- S_BOOT:
  - fetch_valid=0 for exactly one cycle after rst deasserts, giving IMEM one cycle of recovery time.
  - Next state is S_RUN, unless redirect_valid is high that cycle; then pc_q=redirect_target and next state is S_RUN.
- Outputs (combinational from pc_q):
  - instr0_pc=pc_q; instr1_pc=pc_q+4.
  - fetch_valid=(state==S_RUN).
  - instr1_valid=fetch_valid & ~pc_q[2] & ~instr0_btb_hit. Slot 1 is invalid when the bundle starts at an odd word or slot 0 is predicted taken.
  - pred_taken=fetch_valid & (instr0_btb_hit | (~pc_q[2] & instr1_btb_hit)).
- Next-PC priority in S_RUN (highest first):
  1. redirect_valid: pc_q<=redirect_target with bits[1:0] forced to 0. Applied in the next cycle regardless of if_ready. The current bundle is not counted as accepted.
  2. halt_req with no redirect: state<=S_HALT, pc_q holds. halt_req is ignored in S_BOOT/S_HALT.
  3. if_ready=0: pc_q holds. BTB outputs re-evaluate on the same PC, so prediction is stable under stall.
  4. if_ready=1 and instr0_btb_hit: pc_q<=instr0_btb_target_addr.
  5. if_ready=1, ~pc_q[2] and instr1_btb_hit: pc_q<=instr1_btb_target_addr.
  6. if_ready=1 otherwise: pc_q<=(pc_q+8)&~7 (sequential). This yields +8 from an aligned PC and +4 from an odd-word PC.
- Single-cycle next-PC latency: the new PC is visible the cycle after the decision.
- S_HALT:
  - fetch_valid=0.
  - Exit only on redirect_valid: pc_q<=target, state<=S_RUN.
  - halt_req and redirect_valid together in S_RUN: redirect wins and state stays S_RUN.
- Arithmetic: all PC adds are modulo 2^XLEN_WIDTH, so 32'hFFFF_FFF8 sequential wraps to 32'h0.
- If instr1_btb_hit is high while pc_q[2]=1, it is ignored.

Optional Feature:
- Macro: FETCH_PC_GEN_PERF_CNT_EN.
- Defined:
  - perf_redirect_cnt increments on every cycle with redirect_valid=1 in any non-reset state.
  - perf_pred_taken_cnt increments when pred_taken & if_ready & ~redirect_valid.
  - Both are 32-bit, wrap at 2^32, and are cleared only by rst.
- Not defined: both ports are tied to 32'h0 and no counter flops are synthesized.

Test Plan:
- Reset release, BOOT_ADDR=0, if_ready=1, no hits:
  - fetch_valid=0 in the first cycle, then PCs 0x0, 0x8, 0x10.
  - instr1_valid=1 and instr1_pc=instr0_pc+4 each cycle.
- Redirect to 0x104 while if_ready=0:
  - next cycle instr0_pc=0x104, instr1_valid=0.
  - following accepted bundle 0x108.
  - redirect to 0x103 yields 0x100.
- At pc 0x20:
  - instr1_btb_hit=1, target 0x400: next PC 0x400, pred_taken=1.
  - with instr0_btb_hit=1, target 0x80, also present: next PC 0x80, instr1_valid=0.
- if_ready=0 for 3 cycles at pc 0x40 with instr0_btb_hit: PC stays 0x40, then 0x80 on the cycle after if_ready=1.
- halt_req in S_RUN at 0x60:
  - fetch_valid=0 and PC frozen until redirect to 0x200, then fetch resumes at 0x200.
  - same-cycle halt_req and redirect go straight to 0x200 running.
- With FETCH_PC_GEN_PERF_CNT_EN: 3 redirects and 2 accepted predicted-taken bundles give counters 3 and 2. rst mid-run clears both and returns the PC to BOOT_ADDR asynchronously.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Next-PC generator for the dual-issue fetch front end: holds the fetch PC and picks the next 8-byte bundle.
// Optional performance counters are built when FETCH_PC_GEN_PERF_CNT_EN is defined.
module fetch_pc_gen #(
    parameter int                      XLEN_WIDTH = 32,
    parameter logic [XLEN_WIDTH-1:0]   BOOT_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_ready,
    input  logic                  redirect_valid,
    input  logic [XLEN_WIDTH-1:0] redirect_target,
    input  logic                  halt_req,
    input  logic                  instr0_btb_hit,
    input  logic [XLEN_WIDTH-1:0] instr0_btb_target_addr,
    input  logic                  instr1_btb_hit,
    input  logic [XLEN_WIDTH-1:0] instr1_btb_target_addr,
    output logic [XLEN_WIDTH-1:0] instr0_pc,
    output logic [XLEN_WIDTH-1:0] instr1_pc,
    output logic                  fetch_valid,
    output logic                  instr1_valid,
    output logic                  pred_taken,
    output logic [31:0]           perf_redirect_cnt,
    output logic [31:0]           perf_pred_taken_cnt,
    output logic [1:0]            state_dbg
);

    // Debug encoding is stable: 0 = boot, 1 = run, 2 = halt.
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [XLEN_WIDTH-1:0] WORD_MASK   = ~XLEN_WIDTH'(3);
    localparam logic [XLEN_WIDTH-1:0] BUNDLE_MASK = ~XLEN_WIDTH'(7);

    state_e                  state_q, state_d;
    logic [XLEN_WIDTH-1:0]   pc_q, pc_d;
    logic [XLEN_WIDTH-1:0]   redirect_pc;
    logic [XLEN_WIDTH-1:0]   seq_pc;
    logic                    odd_word;

    assign odd_word    = pc_q[2];
    assign redirect_pc = redirect_target & WORD_MASK;
    // Rounds up to the next bundle boundary: +8 when aligned, +4 from an odd word.
    assign seq_pc      = (pc_q + XLEN_WIDTH'(8)) & BUNDLE_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= BOOT_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (redirect_valid) pc_d = redirect_pc;
            end
            S_RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (if_ready) begin
                    if (instr0_btb_hit)                     pc_d = instr0_btb_target_addr;
                    else if (!odd_word && instr1_btb_hit)   pc_d = instr1_btb_target_addr;
                    else                                    pc_d = seq_pc;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
                pc_d    = BOOT_ADDR;
            end
        endcase
    end

    assign instr0_pc    = pc_q;
    assign instr1_pc    = pc_q + XLEN_WIDTH'(4);
    assign fetch_valid  = (state_q == S_RUN);
    assign instr1_valid = fetch_valid & ~odd_word & ~instr0_btb_hit;
    assign pred_taken   = fetch_valid & (instr0_btb_hit | (~odd_word & instr1_btb_hit));
    assign state_dbg    = state_q;

`ifdef FETCH_PC_GEN_PERF_CNT_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] taken_cnt_q;

    // A redirect squashes the current bundle, so it never counts as an accepted prediction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            taken_cnt_q    <= '0;
        end else begin
            if (redirect_valid)
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (pred_taken && if_ready && !redirect_valid)
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign perf_redirect_cnt   = redirect_cnt_q;
    assign perf_pred_taken_cnt = taken_cnt_q;
`else
    assign perf_redirect_cnt   = 32'h0;
    assign perf_pred_taken_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed steps then random steps against a behavioural PC model.
// Counter expectations follow FETCH_PC_GEN_PERF_CNT_EN when the bench is built with it.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        instr0_btb_hit;
    logic [31:0] instr0_btb_target_addr;
    logic        instr1_btb_hit;
    logic [31:0] instr1_btb_target_addr;
    logic [31:0] instr0_pc;
    logic [31:0] instr1_pc;
    logic        fetch_valid;
    logic        instr1_valid;
    logic        pred_taken;
    logic [31:0] perf_redirect_cnt;
    logic [31:0] perf_pred_taken_cnt;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = waiting one boot cycle, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_rcnt;
    logic [31:0] m_tcnt;

    fetch_pc_gen #(.XLEN_WIDTH(32), .BOOT_ADDR(32'h0)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .if_ready               (if_ready),
        .redirect_valid         (redirect_valid),
        .redirect_target        (redirect_target),
        .halt_req               (halt_req),
        .instr0_btb_hit         (instr0_btb_hit),
        .instr0_btb_target_addr (instr0_btb_target_addr),
        .instr1_btb_hit         (instr1_btb_hit),
        .instr1_btb_target_addr (instr1_btb_target_addr),
        .instr0_pc              (instr0_pc),
        .instr1_pc              (instr1_pc),
        .fetch_valid            (fetch_valid),
        .instr1_valid           (instr1_valid),
        .pred_taken             (pred_taken),
        .perf_redirect_cnt      (perf_redirect_cnt),
        .perf_pred_taken_cnt    (perf_pred_taken_cnt),
        .state_dbg              (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_rcnt = 32'h0;
        m_tcnt = 32'h0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, clock, then advance the model.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt,
                        input logic hlt, input logic h0, input logic [31:0] t0,
                        input logic h1, input logic [31:0] t1);
        logic fv, i1v, pt, odd;
        if_ready               = rdy;
        redirect_valid         = redir;
        redirect_target        = tgt;
        halt_req               = hlt;
        instr0_btb_hit         = h0;
        instr0_btb_target_addr = t0;
        instr1_btb_hit         = h1;
        instr1_btb_target_addr = t1;
        #1;
        odd = m_pc[2];
        fv  = (m_mode == 1);
        i1v = fv && !odd && !h0;
        pt  = fv && (h0 || (!odd && h1));
        chk("instr0_pc",    instr0_pc, m_pc);
        chk("instr1_pc",    instr1_pc, m_pc + 32'd4);
        chk("fetch_valid",  {31'b0, fetch_valid}, {31'b0, fv});
        chk("instr1_valid", {31'b0, instr1_valid}, {31'b0, i1v});
        chk("pred_taken",   {31'b0, pred_taken}, {31'b0, pt});
        chk("perf_redir",   perf_redirect_cnt, m_rcnt);
        chk("perf_taken",   perf_pred_taken_cnt, m_tcnt);
        chk("state_dbg",    {30'b0, state_dbg}, m_mode);
`ifdef FETCH_PC_GEN_PERF_CNT_EN
        if (redir) m_rcnt = m_rcnt + 32'd1;
        if (pt && rdy && !redir) m_tcnt = m_tcnt + 32'd1;
`endif
        case (m_mode)
            0: begin
                if (redir) m_pc = tgt & 32'hFFFF_FFFC;
                m_mode = 1;
            end
            1: begin
                if (redir)                  m_pc = tgt & 32'hFFFF_FFFC;
                else if (hlt)               m_mode = 2;
                else if (rdy) begin
                    if (h0)                 m_pc = t0;
                    else if (!odd && h1)    m_pc = t1;
                    else                    m_pc = (m_pc + 32'd8) & 32'hFFFF_FFF8;
                end
            end
            default: begin
                if (redir) begin
                    m_pc   = tgt & 32'hFFFF_FFFC;
                    m_mode = 1;
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_pc",       instr0_pc, 32'h0);
        chk("rst_fv",       {31'b0, fetch_valid}, 32'h0);
        chk("rst_i1v",      {31'b0, instr1_valid}, 32'h0);
        chk("rst_cnt_redir", perf_redirect_cnt, 32'h0);
        chk("rst_cnt_taken", perf_pred_taken_cnt, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0;
        instr0_btb_hit = 1'b0; instr0_btb_target_addr = '0;
        instr1_btb_hit = 1'b0; instr1_btb_target_addr = '0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_pc", instr0_pc, 32'h0);
        chk("reset_fv", {31'b0, fetch_valid}, 32'h0);
        chk("reset_pt", {31'b0, pred_taken}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Boot cycle then sequential bundles 0x0, 0x8, 0x10
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("boot_then_run", {31'b0, fetch_valid}, 32'h1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_8", instr0_pc, 32'h8);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_10", instr0_pc, 32'h10);

        // Redirect under stall, odd-word bundle, unaligned target
        step(0, 1, 32'h104, 0, 0, 0, 0, 0);
        chk("redir_104", instr0_pc, 32'h104);
        chk("redir_104_i1v", {31'b0, instr1_valid}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("odd_seq_108", instr0_pc, 32'h108);
        step(1, 1, 32'h103, 0, 0, 0, 0, 0);
        chk("redir_103", instr0_pc, 32'h100);

        // Slot-1 and slot-0 BTB hits at 0x20
        step(1, 1, 32'h20, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 32'h400);
        chk("btb1_400", instr0_pc, 32'h400);
        step(1, 1, 32'h20, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h80, 1, 32'h400);
        chk("btb0_wins_80", instr0_pc, 32'h80);

        // Stall with a slot-0 hit holds the PC
        step(1, 1, 32'h40, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 32'h80, 0, 0);
        chk("stall_40", instr0_pc, 32'h40);
        step(1, 0, 0, 0, 1, 32'h80, 0, 0);
        chk("stall_release_80", instr0_pc, 32'h80);

        // Halt, resume by redirect, then halt+redirect together
        step(1, 1, 32'h60, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("halt_pc", instr0_pc, 32'h60);
        chk("halt_fv", {31'b0, fetch_valid}, 32'h0);
        repeat (2) step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 32'h200, 0, 0, 0, 0, 0);
        chk("resume_200", instr0_pc, 32'h200);
        step(1, 1, 32'h200, 1, 0, 0, 0, 0);
        chk("halt_redir_fv", {31'b0, fetch_valid}, 32'h1);

        // Wrap-around and slot-1 hit ignored on an odd word
        step(1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_0", instr0_pc, 32'h0);
        step(1, 1, 32'h24, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 32'h998);
        chk("odd_ignore_h1", instr0_pc, 32'h28);

        // Counter segment: pending redirect discarded by reset, then 3 redirects and 2 accepted predictions
        redirect_valid = 1'b1; redirect_target = 32'h700;
        mid_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h300, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 32'h500);
        step(0, 1, 32'h600, 0, 0, 0, 0, 0);
        step(1, 1, 32'h640, 0, 1, 32'h900, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_PC_GEN_PERF_CNT_EN
        chk("cnt_redir_3", perf_redirect_cnt, 32'd3);
        chk("cnt_taken_2", perf_pred_taken_cnt, 32'd2);
`else
        chk("cnt_redir_off", perf_redirect_cnt, 32'd0);
        chk("cnt_taken_off", perf_pred_taken_cnt, 32'd0);
`endif
        mid_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) == 0,
                     $urandom,
                     $urandom_range(0, 19) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 3) == 0,
                     $urandom & 32'hFFFF_FFFC);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
